// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: walks ARK/SUB/SHF/MIX step units and supplies the round index.
// Optional per-step watchdog is enabled by defining AES_CTRL_TIMEOUT_EN.
module aes_round_ctrl #(
  parameter int unsigned NR      = 10,
  parameter int unsigned TMO_CYC = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sub_done,
  input  logic       shf_done,
  input  logic       mix_done,
  input  logic       ark_done,
  output logic       sub_en,
  output logic       shf_en,
  output logic       mix_en,
  output logic       ark_en,
  output logic       load_pt,
  output logic [3:0] round,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {StIdle, StLoad, StArk, StSub, StShf, StMix, StFin} state_e;

  localparam logic [3:0] NrL = 4'(NR);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       timeout;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          round_d = '0;
        end
      end
      StLoad: state_d = StArk;
      StArk: begin
        if (ark_done) begin
          if (round_q == NrL) begin
            state_d = StFin;
          end else begin
            round_d = round_q + 4'd1;
            state_d = StSub;
          end
        end
      end
      StSub: if (sub_done) state_d = StShf;
      StShf: if (shf_done) state_d = (round_q < NrL) ? StMix : StArk;
      StMix: if (mix_done) state_d = StArk;
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (timeout) state_d = StIdle;
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      round_q <= '0;
      sub_en  <= 1'b0;
      shf_en  <= 1'b0;
      mix_en  <= 1'b0;
      ark_en  <= 1'b0;
      load_pt <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      sub_en  <= (state_d == StSub);
      shf_en  <= (state_d == StShf);
      mix_en  <= (state_d == StMix);
      ark_en  <= (state_d == StArk);
      load_pt <= (state_d == StLoad);
      busy    <= (state_d != StIdle);
      done    <= (state_d == StFin);
    end
  end

  assign round = round_q;

`ifdef AES_CTRL_TIMEOUT_EN
  logic [4:0] cnt_q;
  logic       err_q;
  logic       step_st;
  logic       step_done;

  assign step_st   = state_q inside {StArk, StSub, StShf, StMix};
  assign step_done = ((state_q == StArk) & ark_done) | ((state_q == StSub) & sub_done) |
                     ((state_q == StShf) & shf_done) | ((state_q == StMix) & mix_done);
  assign timeout   = step_st & ~step_done & (cnt_q == 5'(TMO_CYC - 1));

  // Counter restarts on every state change, so it measures time spent in the current step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (step_st && cnt_q != 5'h1f) begin
        cnt_q <= cnt_q + 5'd1;
      end
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
